// File: rtl/ethernet_receive_que_slot_if.sv
// Fabric-side read stream of one receive queue slot: committed-frame
// indication with length, and a byte stream with valid/ready/last.
interface ethernet_receive_que_slot_if;
    logic        frame_available;
    logic [15:0] frame_length;
    logic [7:0]  read_data;
    logic        read_data_valid;
    logic        read_data_last;
    logic        read_data_ready;

    modport master (
        output frame_available,
        output frame_length,
        output read_data,
        output read_data_valid,
        output read_data_last,
        input  read_data_ready
    );

    modport slave (
        input  frame_available,
        input  frame_length,
        input  read_data,
        input  read_data_valid,
        input  read_data_last,
        output read_data_ready
    );
endinterface

// File: rtl/ethernet_receive_que_slot.sv
// Receive queue slot behind the Ethernet packet parser. Bytes are buffered
// speculatively, then committed (FCS stripped) on good_packet or rolled back
// on bad_packet. Committed frames are streamed out, each announced by its
// length from a small FIFO.
// Optional statistics counters: define RECEIVE_QUE_SLOT_STATISTICS_EN.
module ethernet_receive_que_slot #(
    parameter int unsigned DEPTH           = 4096,
    parameter int unsigned MAX_FRAME_BYTES = 1522,
    parameter int unsigned MAX_FRAMES      = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [7:0]                  packet_data,
    input  logic                        packet_data_valid,
    input  logic                        good_packet,
    input  logic                        bad_packet,
    output logic                        receive_slot_enable,
    ethernet_receive_que_slot_if.master rd,
    output logic [15:0]                 good_frame_count,
    output logic [15:0]                 bad_frame_count,
    output logic [15:0]                 overflow_count
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned FW  = $clog2(MAX_FRAMES);
    localparam int unsigned FPW = FW + 1;

    localparam logic [PW-1:0]  DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0]  MAXF_P   = PW'(MAX_FRAME_BYTES);
    localparam logic [FPW-1:0] FRAMES_P = FPW'(MAX_FRAMES);

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_t;

    // Storage
    logic [7:0]     mem_q     [DEPTH];
    logic [15:0]    len_mem_q [MAX_FRAMES];
    logic [7:0]     ram_rdata_q;

    // Write side
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  commit_ptr_q, commit_ptr_d;
    logic [15:0]    frame_bytes_q, frame_bytes_d;
    logic           overflow_q, overflow_d;
    logic [FPW-1:0] lf_wr_q;
    logic           receive_slot_enable_q;

    // Read side
    rd_state_t      state_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [FPW-1:0] lf_rd_q;
    logic [15:0]    remaining_q;
    logic [7:0]     read_data_q;
    logic           read_data_valid_q;
    logic           read_data_last_q;

    // Combinational helpers
    logic [PW-1:0]  fill;
    logic           accept;
    logic [PW-1:0]  wp_now;
    logic [15:0]    fb_now;
    logic           ovf_now;
    logic           commit;
    logic           drop;
    logic           lf_full;
    logic           lf_empty;
    logic [15:0]    head_len;
    logic           fire;
    logic           ram_rd_en;
    logic [AW-1:0]  ram_raddr;

    assign lf_empty = (lf_wr_q == lf_rd_q);
    assign lf_full  = ((lf_wr_q - lf_rd_q) == FRAMES_P);
    assign head_len = len_mem_q[lf_rd_q[FW-1:0]];
    assign fire     = read_data_valid_q && rd.read_data_ready;

    // Accept/commit/drop decision; a byte in the same cycle as good/bad counts first.
    always_comb begin
        fill    = wr_ptr_q - rd_ptr_q;
        accept  = packet_data_valid && (fill != DEPTH_P);
        wp_now  = wr_ptr_q + PW'(accept);
        fb_now  = (accept && (frame_bytes_q != 16'hFFFF)) ? frame_bytes_q + 16'd1
                                                           : frame_bytes_q;
        ovf_now = overflow_q || (packet_data_valid && !accept);
        commit  = good_packet && !bad_packet && !ovf_now && (fb_now > 16'd4) && !lf_full;
        drop    = bad_packet || (good_packet && !commit);

        wr_ptr_d      = wp_now;
        commit_ptr_d  = commit_ptr_q;
        frame_bytes_d = fb_now;
        overflow_d    = ovf_now;
        if (commit) begin
            // wr_ptr also steps back over the FCS so the next frame lands
            // directly after this one and the read stream stays contiguous.
            wr_ptr_d      = wp_now - PW'(4);
            commit_ptr_d  = wp_now - PW'(4);
            frame_bytes_d = '0;
            overflow_d    = 1'b0;
        end else if (drop) begin
            wr_ptr_d      = commit_ptr_q;
            frame_bytes_d = '0;
            overflow_d    = 1'b0;
        end
    end

    // Buffer RAM read control; rdata always holds the byte after the one on the output.
    always_comb begin
        ram_rd_en = 1'b0;
        ram_raddr = rd_ptr_q[AW-1:0];
        case (state_q)
            R_IDLE: begin
                ram_rd_en = !lf_empty;
                ram_raddr = rd_ptr_q[AW-1:0];
            end
            R_FETCH: begin
                ram_rd_en = (remaining_q > 16'd1);
                ram_raddr = rd_ptr_q[AW-1:0] + AW'(1);
            end
            R_STREAM: begin
                ram_rd_en = fire && (remaining_q > 16'd2);
                ram_raddr = rd_ptr_q[AW-1:0] + AW'(2);
            end
            default: begin
                ram_rd_en = 1'b0;
                ram_raddr = rd_ptr_q[AW-1:0];
            end
        endcase
    end

    // Byte buffer write port
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= packet_data;
        end
    end

    // Byte buffer registered read port
    always_ff @(posedge clock) begin
        if (ram_rd_en) begin
            ram_rdata_q <= mem_q[ram_raddr];
        end
    end

    // Length FIFO write on commit (FCS excluded)
    always_ff @(posedge clock) begin
        if (commit) begin
            len_mem_q[lf_wr_q[FW-1:0]] <= fb_now - 16'd4;
        end
    end

    // Write-side pointers, frame state and space advertisement
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q              <= '0;
            commit_ptr_q          <= '0;
            frame_bytes_q         <= '0;
            overflow_q            <= 1'b0;
            lf_wr_q               <= '0;
            receive_slot_enable_q <= 1'b0;
        end else begin
            wr_ptr_q              <= wr_ptr_d;
            commit_ptr_q          <= commit_ptr_d;
            frame_bytes_q         <= frame_bytes_d;
            overflow_q            <= overflow_d;
            if (commit) begin
                lf_wr_q <= lf_wr_q + FPW'(1);
            end
            receive_slot_enable_q <= ((DEPTH_P - fill) >= MAXF_P) && !lf_full &&
                                     (frame_bytes_q == 16'd0);
        end
    end

    // Read FSM: fetch head frame, then stream one byte per accepted handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= R_IDLE;
            rd_ptr_q          <= '0;
            lf_rd_q           <= '0;
            remaining_q       <= '0;
            read_data_q       <= '0;
            read_data_valid_q <= 1'b0;
            read_data_last_q  <= 1'b0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (!lf_empty) begin
                        remaining_q <= head_len;
                        state_q     <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    read_data_q       <= ram_rdata_q;
                    read_data_valid_q <= 1'b1;
                    read_data_last_q  <= (remaining_q == 16'd1);
                    state_q           <= R_STREAM;
                end
                R_STREAM: begin
                    if (fire) begin
                        rd_ptr_q    <= rd_ptr_q + PW'(1);
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            read_data_valid_q <= 1'b0;
                            read_data_last_q  <= 1'b0;
                            lf_rd_q           <= lf_rd_q + FPW'(1);
                            state_q           <= R_IDLE;
                        end else begin
                            read_data_q      <= ram_rdata_q;
                            read_data_last_q <= (remaining_q == 16'd2);
                        end
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign receive_slot_enable = receive_slot_enable_q;
    assign rd.frame_available  = !lf_empty;
    assign rd.frame_length     = lf_empty ? 16'd0 : head_len;
    assign rd.read_data        = read_data_q;
    assign rd.read_data_valid  = read_data_valid_q;
    assign rd.read_data_last   = read_data_last_q;

`ifdef RECEIVE_QUE_SLOT_STATISTICS_EN
    logic [15:0] good_cnt_q;
    logic [15:0] bad_cnt_q;
    logic [15:0] ovf_cnt_q;

    // Saturating frame statistics
    always_ff @(posedge clock) begin
        if (reset) begin
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (commit && (good_cnt_q != 16'hFFFF)) begin
                good_cnt_q <= good_cnt_q + 16'd1;
            end
            if (drop && (bad_cnt_q != 16'hFFFF)) begin
                bad_cnt_q <= bad_cnt_q + 16'd1;
            end
            if (drop && ovf_now && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
        end
    end

    assign good_frame_count = good_cnt_q;
    assign bad_frame_count  = bad_cnt_q;
    assign overflow_count   = ovf_cnt_q;
`else
    assign good_frame_count = '0;
    assign bad_frame_count  = '0;
    assign overflow_count   = '0;
`endif

endmodule

// File: tb/tb_ethernet_receive_que_slot.sv
// Directed self-checking bench for ethernet_receive_que_slot (default parameters).
module tb_ethernet_receive_que_slot;

`ifdef RECEIVE_QUE_SLOT_STATISTICS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [7:0]  packet_data;
    logic        packet_data_valid;
    logic        good_packet;
    logic        bad_packet;
    logic        receive_slot_enable;
    logic [15:0] good_frame_count;
    logic [15:0] bad_frame_count;
    logic [15:0] overflow_count;

    int checks;
    int errors;

    ethernet_receive_que_slot_if rq_if ();

    ethernet_receive_que_slot #(
        .DEPTH           (4096),
        .MAX_FRAME_BYTES (1522),
        .MAX_FRAMES      (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .packet_data         (packet_data),
        .packet_data_valid   (packet_data_valid),
        .good_packet         (good_packet),
        .bad_packet          (bad_packet),
        .receive_slot_enable (receive_slot_enable),
        .rd                  (rq_if),
        .good_frame_count    (good_frame_count),
        .bad_frame_count     (bad_frame_count),
        .overflow_count      (overflow_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic do_reset();
        reset                 = 1'b1;
        packet_data           = '0;
        packet_data_valid     = 1'b0;
        good_packet           = 1'b0;
        bad_packet            = 1'b0;
        rq_if.read_data_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_frame(input int n, input int base, input bit good, input bit bad);
        for (int i = 0; i < n; i++) begin
            packet_data       = 8'(base + i);
            packet_data_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        packet_data_valid = 1'b0;
        good_packet       = good;
        bad_packet        = bad;
        @(posedge clock);
        #1;
        good_packet = 1'b0;
        bad_packet  = 1'b0;
    endtask

    task automatic drain_frame(input int exp_len, input int base, input bit idle_after);
        int cyc;
        int cnt;
        int extra;
        int local_err;
        logic [7:0] eb;
        cyc = 0;
        while (rq_if.frame_available !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (rq_if.frame_available !== 1'b1) begin
            errors++;
            $display("FAIL drain_avail: frame_available=%b required 1", rq_if.frame_available);
        end
        checks++;
        if (rq_if.frame_length !== 16'(exp_len)) begin
            errors++;
            $display("FAIL drain_length: frame_length=%0d required %0d", rq_if.frame_length, exp_len);
        end
        rq_if.read_data_ready = 1'b1;
        cnt       = 0;
        cyc       = 0;
        local_err = 0;
        while (cnt < exp_len && cyc < exp_len + 50) begin
            @(negedge clock);
            cyc++;
            if (rq_if.read_data_valid === 1'b1) begin
                eb = 8'(base + cnt);
                checks++;
                if (rq_if.read_data !== eb || rq_if.read_data_last !== (cnt == exp_len - 1)) begin
                    errors++;
                    if (local_err < 5)
                        $display("FAIL drain_byte[%0d]: data=%02h last=%b required data=%02h last=%b",
                                 cnt, rq_if.read_data, rq_if.read_data_last, eb, (cnt == exp_len - 1));
                    local_err++;
                end
                cnt++;
            end
        end
        checks++;
        if (cnt != exp_len) begin
            errors++;
            $display("FAIL drain_count: bytes=%0d required %0d", cnt, exp_len);
        end
        @(posedge clock);
        #1;
        if (idle_after) begin
            extra = 0;
            repeat (6) begin
                @(negedge clock);
                if (rq_if.read_data_valid === 1'b1) extra++;
            end
            checks++;
            if (extra != 0 || rq_if.frame_available !== 1'b0) begin
                errors++;
                $display("FAIL drain_idle: extra_bytes=%0d frame_available=%b required 0 and 0",
                         extra, rq_if.frame_available);
            end
            @(posedge clock);
            #1;
        end
        rq_if.read_data_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // partial frame, then reset mid-frame
        for (int i = 0; i < 30; i++) begin
            packet_data       = 8'(i);
            packet_data_valid = 1'b1;
            @(posedge clock);
            #1;
        end
        packet_data_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (rq_if.frame_available !== 1'b0 || rq_if.frame_length !== 16'd0 ||
            rq_if.read_data_valid !== 1'b0 || rq_if.read_data_last !== 1'b0 ||
            rq_if.read_data !== 8'd0 || receive_slot_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: avail=%b len=%0d valid=%b last=%b data=%02h en=%b required all 0",
                     rq_if.frame_available, rq_if.frame_length, rq_if.read_data_valid,
                     rq_if.read_data_last, rq_if.read_data, receive_slot_enable);
        end
        checks++;
        if (good_frame_count !== 16'd0 || bad_frame_count !== 16'd0 || overflow_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_stats: good=%0d bad=%0d ovf=%0d required 0 0 0",
                     good_frame_count, bad_frame_count, overflow_count);
        end
        reset = 1'b0;
        // good_packet after reset must find no bytes and drop
        good_packet = 1'b1;
        @(posedge clock);
        #1;
        good_packet = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rq_if.frame_available !== 1'b0 || receive_slot_enable !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard: avail=%b en=%b required 0 and 1",
                     rq_if.frame_available, receive_slot_enable);
        end
    endtask

    task automatic test_basic();
        do_reset();
        drive_frame(64, 8'h00, 1'b1, 1'b0);
        drain_frame(60, 8'h00, 1'b1);
        checks++;
        if (good_frame_count !== (STATS ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL basic_good_count: got %0d required %0d", good_frame_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_bad_then_good();
        do_reset();
        drive_frame(100, 8'h80, 1'b0, 1'b1);
        drive_frame(70, 8'h10, 1'b1, 1'b0);
        drain_frame(66, 8'h10, 1'b1);
        checks++;
        if (bad_frame_count !== (STATS ? 16'd1 : 16'd0) ||
            good_frame_count !== (STATS ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL bad_good_stats: bad=%0d good=%0d required %0d %0d",
                     bad_frame_count, good_frame_count, STATS ? 1 : 0, STATS ? 1 : 0);
        end
    endtask

    task automatic test_min_frame();
        do_reset();
        // exactly the FCS: nothing to commit
        drive_frame(4, 8'h60, 1'b1, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rq_if.frame_available !== 1'b0) begin
            errors++;
            $display("FAIL min4_dropped: frame_available=%b required 0", rq_if.frame_available);
        end
        drive_frame(5, 8'h70, 1'b1, 1'b0);
        drain_frame(1, 8'h70, 1'b1);
    endtask

    task automatic test_enable();
        do_reset();
        drive_frame(1522, 8'h00, 1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (receive_slot_enable !== 1'b1) begin
            errors++;
            $display("FAIL enable_one_frame: en=%b required 1", receive_slot_enable);
        end
        drive_frame(1522, 8'h55, 1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (receive_slot_enable !== 1'b0) begin
            errors++;
            $display("FAIL enable_two_frames: en=%b required 0", receive_slot_enable);
        end
        drain_frame(1518, 8'h00, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (receive_slot_enable !== 1'b1) begin
            errors++;
            $display("FAIL enable_after_drain: en=%b required 1", receive_slot_enable);
        end
        drain_frame(1518, 8'h55, 1'b1);
    endtask

    task automatic test_overflow();
        do_reset();
        drive_frame(1522, 8'h20, 1'b1, 1'b0);
        drive_frame(1522, 8'h40, 1'b1, 1'b0);
        drive_frame(2000, 8'h99, 1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (overflow_count !== (STATS ? 16'd1 : 16'd0) ||
            bad_frame_count !== (STATS ? 16'd1 : 16'd0) ||
            good_frame_count !== (STATS ? 16'd2 : 16'd0)) begin
            errors++;
            $display("FAIL overflow_stats: ovf=%0d bad=%0d good=%0d required %0d %0d %0d",
                     overflow_count, bad_frame_count, good_frame_count,
                     STATS ? 1 : 0, STATS ? 1 : 0, STATS ? 2 : 0);
        end
        drain_frame(1518, 8'h20, 1'b0);
        drain_frame(1518, 8'h40, 1'b1);
    endtask

    task automatic test_backpressure();
        int cyc;
        int cnt;
        int extra;
        bit prev_stall;
        logic [7:0] pd;
        logic pl;
        do_reset();
        drive_frame(10, 8'hA0, 1'b1, 1'b0);
        cyc = 0;
        while (rq_if.frame_available !== 1'b1 && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        checks++;
        if (rq_if.frame_length !== 16'd6) begin
            errors++;
            $display("FAIL bp_length: frame_length=%0d required 6", rq_if.frame_length);
        end
        rq_if.read_data_ready = 1'b0;
        prev_stall = 1'b0;
        pd  = '0;
        pl  = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 6 && cyc < 60) begin
            @(posedge clock);
            #1;
            rq_if.read_data_ready = ~rq_if.read_data_ready;
            @(negedge clock);
            cyc++;
            if (rq_if.read_data_valid === 1'b1) begin
                if (prev_stall) begin
                    checks++;
                    if (rq_if.read_data !== pd || rq_if.read_data_last !== pl) begin
                        errors++;
                        $display("FAIL bp_stable: data=%02h last=%b required %02h %b",
                                 rq_if.read_data, rq_if.read_data_last, pd, pl);
                    end
                end
                if (rq_if.read_data_ready === 1'b1) begin
                    checks++;
                    if (rq_if.read_data !== 8'(8'hA0 + cnt) || rq_if.read_data_last !== (cnt == 5)) begin
                        errors++;
                        $display("FAIL bp_byte[%0d]: data=%02h last=%b required %02h %b",
                                 cnt, rq_if.read_data, rq_if.read_data_last, 8'(8'hA0 + cnt), (cnt == 5));
                    end
                    cnt++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                end
                pd = rq_if.read_data;
                pl = rq_if.read_data_last;
            end
        end
        @(posedge clock);
        #1;
        rq_if.read_data_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clock);
            if (rq_if.read_data_valid === 1'b1) extra++;
        end
        checks++;
        if (cnt != 6 || extra != 0) begin
            errors++;
            $display("FAIL bp_count: bytes=%0d extra=%0d required 6 and 0", cnt, extra);
        end
        @(posedge clock);
        #1;
        rq_if.read_data_ready = 1'b0;
    endtask

    task automatic test_good_bad_same();
        do_reset();
        drive_frame(20, 8'hC0, 1'b1, 1'b1);
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (rq_if.frame_available !== 1'b0) begin
            errors++;
            $display("FAIL gb_same_dropped: frame_available=%b required 0", rq_if.frame_available);
        end
        // the dropped bytes must have been rolled back
        drive_frame(10, 8'h30, 1'b1, 1'b0);
        drain_frame(6, 8'h30, 1'b1);
        checks++;
        if (bad_frame_count !== (STATS ? 16'd1 : 16'd0) ||
            good_frame_count !== (STATS ? 16'd1 : 16'd0)) begin
            errors++;
            $display("FAIL gb_same_stats: bad=%0d good=%0d required %0d %0d",
                     bad_frame_count, good_frame_count, STATS ? 1 : 0, STATS ? 1 : 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_bad_then_good();
        test_min_frame();
        test_enable();
        test_overflow();
        test_backpressure();
        test_good_bad_same();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
